// File: rtl/int_ext_arbiter.sv
// int_ext_arbiter: round-robin shared 8/16->32 integer-extension stage; `INT_EXT_ARB_STATS_EN adds neg_count
module int_ext_arbiter #(
  parameter int NREQ  = 4,
  parameter int SRC_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0]  req_kind,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [1:0]         out_kind,
  output logic [SRC_W-1:0]   out_src
`ifdef INT_EXT_ARB_STATS_EN
  ,
  output logic [15:0]        neg_count
`endif
);
  if (SRC_W != $clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
    $error("int_ext_arbiter: SRC_W must equal clog2(NREQ), NREQ in 2..8");
  end
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_d;
  logic [SRC_W-1:0] ptr, gnt;
  logic found, free, accept;
  logic [15:0] sel_data;
  logic [1:0] sel_kind;
  logic [31:0] ext;
  assign out_valid = state == FULL;
  always_comb begin
    free = !rst && (state == EMPTY || out_ready);
    found = 1'b0;
    gnt = '0;
    // descending scan so the lowest offset from ptr wins
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gnt = SRC_W'((int'(ptr) + k) % NREQ);
      end
    accept = free && found;
    req_ready = '0;
    sel_data = '0;
    sel_kind = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt == SRC_W'(i)) begin
        req_ready[i] = accept;
        sel_data = req_data[16*i +: 16];
        sel_kind = req_kind[2*i +: 2];
      end
    ext = sel_kind[1] ? {{16{!sel_kind[0] && sel_data[15]}}, sel_data}
                      : {{24{!sel_kind[0] && sel_data[7]}}, sel_data[7:0]};
    state_d = accept ? FULL : (state == FULL && out_ready) ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      ptr <= '0;
      out_data <= '0;
      out_kind <= '0;
      out_src <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        out_data <= ext;
        out_kind <= sel_kind;
        out_src <= gnt;
        ptr <= SRC_W'((int'(gnt) + 1) % NREQ);
      end
    end
  end
`ifdef INT_EXT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) neg_count <= '0;
    else if (accept && ext[31]) neg_count <= neg_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_int_ext_arbiter.sv
// tb_int_ext_arbiter: table-driven vectors plus directed multi-cycle sequences
module tb_int_ext_arbiter;
  logic clk = 0, rst = 1, out_ready = 0, out_valid;
  logic [3:0] req_valid = 0, req_ready;
  logic [63:0] req_data = 0;
  logic [7:0] req_kind = 0;
  logic [31:0] out_data;
  logic [1:0] out_kind, out_src;
`ifdef INT_EXT_ARB_STATS_EN
  logic [15:0] neg_count;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  int_ext_arbiter #(.NREQ(4), .SRC_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_kind(req_kind), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_kind(out_kind), .out_src(out_src)
`ifdef INT_EXT_ARB_STATS_EN
    , .neg_count(neg_count)
`endif
  );
  typedef struct {
    logic [3:0] v; logic [63:0] d; logic [7:0] k; logic ordy;
    logic [3:0] rr; logic ov; logic [31:0] od; logic [1:0] ok; logic [1:0] os;
  } vec_t;
  vec_t tbl[$];
  localparam logic [63:0] D = {16'h7F7F, 16'h00C3, 16'h8000, 16'h0001};
  localparam logic [7:0] K = 8'b00_01_10_11;
  function automatic vec_t mk(logic [3:0] v, logic [63:0] d, logic [7:0] k, logic ordy,
                              logic [3:0] rr, logic ov, logic [31:0] od, logic [1:0] ok, logic [1:0] os);
    return '{v, d, k, ordy, rr, ov, od, ok, os};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(string nm, logic [3:0] rr, logic ov, logic [31:0] od, logic [1:0] ok, logic [1:0] os);
    #1 chk({nm, " req_ready"}, 32'(req_ready), 32'(rr));
    @(posedge clk);
    #1 chk({nm, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, " out_data"}, out_data, od);
    chk({nm, " out_kind"}, 32'(out_kind), 32'(ok));
    chk({nm, " out_src"}, 32'(out_src), 32'(os));
  endtask
  task automatic set(logic [3:0] v, logic [63:0] d, logic [7:0] k, logic ordy);
    req_valid = v; req_data = d; req_kind = k; out_ready = ordy;
  endtask
  initial begin
    tbl.push_back(mk(4'h1, 64'h00FF, 8'h00, 1, 4'h1, 1, 32'hFFFFFFFF, 2'd0, 2'd0));
    tbl.push_back(mk(4'h1, 64'h00FE, 8'h01, 1, 4'h1, 1, 32'h000000FE, 2'd1, 2'd0));
    tbl.push_back(mk(4'h1, 64'hFFFD, 8'h02, 1, 4'h1, 1, 32'hFFFFFFFD, 2'd2, 2'd0));
    tbl.push_back(mk(4'h1, 64'hFFFC, 8'h03, 1, 4'h1, 1, 32'h0000FFFC, 2'd3, 2'd0));
    tbl.push_back(mk(4'h1, 64'hAB80, 8'h00, 1, 4'h1, 1, 32'hFFFFFF80, 2'd0, 2'd0));
    tbl.push_back(mk(4'h0, 64'h0, 8'h00, 1, 4'h0, 0, 32'hFFFFFF80, 2'd0, 2'd0));
    tbl.push_back(mk(4'h8, {16'h0012, 48'h0}, 8'hC0, 1, 4'h8, 1, 32'h00000012, 2'd3, 2'd3));
    tbl.push_back(mk(4'hF, D, K, 1, 4'h1, 1, 32'h00000001, 2'd3, 2'd0));
    tbl.push_back(mk(4'hF, D, K, 1, 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1));
    tbl.push_back(mk(4'hF, D, K, 1, 4'h4, 1, 32'h000000C3, 2'd1, 2'd2));
    tbl.push_back(mk(4'hF, D, K, 1, 4'h8, 1, 32'h0000007F, 2'd0, 2'd3));
    tbl.push_back(mk(4'hF, D, K, 1, 4'h1, 1, 32'h00000001, 2'd3, 2'd0));
    tbl.push_back(mk(4'hF, D, K, 1, 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1));
    tbl.push_back(mk(4'h0, D, K, 1, 4'h0, 0, 32'hFFFF8000, 2'd2, 2'd1));
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_kind", 32'(out_kind), 0);
    chk("reset out_src", 32'(out_src), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    foreach (tbl[i]) begin
      set(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].ordy);
      cyc($sformatf("vec%0d", i), tbl[i].rr, tbl[i].ov, tbl[i].od, tbl[i].ok, tbl[i].os);
    end
    set(4'h1, D, K, 1);
    cyc("bp load", 4'h1, 1, 32'h00000001, 2'd3, 2'd0);
    set(4'hF, D, K, 0);
    for (int i = 0; i < 5; i++) cyc($sformatf("bp hold%0d", i), 4'h0, 1, 32'h00000001, 2'd3, 2'd0);
    out_ready = 1;
    cyc("bp release", 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1);
    set(4'hA, D, K, 1);
    cyc("sparse g3a", 4'h8, 1, 32'h0000007F, 2'd0, 2'd3);
    cyc("sparse g1", 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1);
    cyc("sparse g3b", 4'h8, 1, 32'h0000007F, 2'd0, 2'd3);
    cyc("sparse pre", 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1);
    req_valid = 4'h2;
    cyc("sparse drop3", 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1);
    req_valid = 4'h0;
    cyc("sparse drain", 4'h0, 0, 32'hFFFF8000, 2'd2, 2'd1);
    set(4'h4, D, K, 0);
    cyc("rst fill", 4'h4, 1, 32'h000000C3, 2'd1, 2'd2);
    set(4'h0, D, K, 0);
    rst = 1;
    cyc("rst pulse", 4'h0, 0, 32'h0, 2'd0, 2'd0);
    rst = 0;
    set(4'hA, D, K, 1);
    cyc("rst regrant", 4'h2, 1, 32'hFFFF8000, 2'd2, 2'd1);
    req_valid = 0;
    cyc("rst drain", 4'h0, 0, 32'hFFFF8000, 2'd2, 2'd1);
`ifdef INT_EXT_ARB_STATS_EN
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("stats reset", 32'(neg_count), 0);
    set(4'h1, 64'h0080, 8'h00, 1);
    cyc("st b80", 4'h1, 1, 32'hFFFFFF80, 2'd0, 2'd0);
    set(4'h1, 64'h0080, 8'h01, 1);
    cyc("st ub80", 4'h1, 1, 32'h00000080, 2'd1, 2'd0);
    set(4'h1, 64'h8000, 8'h02, 1);
    cyc("st s8000", 4'h1, 1, 32'hFFFF8000, 2'd2, 2'd0);
    set(4'h1, 64'h7FFF, 8'h02, 1);
    cyc("st s7fff", 4'h1, 1, 32'h00007FFF, 2'd2, 2'd0);
    chk("stats count2", 32'(neg_count), 2);
    set(4'h1, 64'h0080, 8'h00, 1);
    repeat (65533) @(posedge clk);
    #1 chk("stats ffff", 32'(neg_count), 32'hFFFF);
    @(posedge clk);
    #1 chk("stats wrap", 32'(neg_count), 0);
    req_valid = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_ext_arbiter.md
Name: int_ext_arbiter

Overview:
- Shares one registered integer-extension datapath between NREQ requesters.
- Each requester presents a 16-bit payload tagged with an SV integer kind: byte, byte unsigned, shortint or shortint unsigned.
- The block grants requesters round-robin, sign- or zero-extends the payload to 32 bits per its kind, and delivers it on a single valid/ready output port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SRC_W, 2, width of the source index; must equal clog2(NREQ), and is checked at elaboration.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_data  input  16*NREQ  payload; requester i occupies bits [16*i+15:16*i]. Byte kinds use the low 8 bits only.
- req_kind  input  2*NREQ  kind code for requester i:
  - 00 = byte (signed)
  - 01 = byte unsigned
  - 10 = shortint (signed)
  - 11 = shortint unsigned
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accept.
- out_data  output  32  extended result.
- out_kind  output  2  kind code of the held result.
- out_src  output  SRC_W  index of the requester that produced the held result.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_kind=0, out_src=0, req_ready=0, round-robin pointer=0, state=EMPTY.
- States:
  - EMPTY: output register empty.
  - FULL: output register holds a result.
- Slot free condition: state==EMPTY, or (state==FULL and out_ready==1). This gives full throughput of one result per cycle.
- Grant:
  - When the slot is free, grant the first requester with req_valid=1, searching from the pointer upward with wrap-around modulo NREQ.
  - The grant drives req_ready combinationally for that requester only.
  - With no valid request, or a slot that is not free, req_ready = 0.
- Accept: a transfer occurs when req_valid[i] and req_ready[i] are both 1. On the next edge:
  - out_data = extension of payload[i];
  - out_kind = req_kind[i];
  - out_src = i;
  - out_valid = 1; state = FULL;
  - pointer = (i+1) mod NREQ.
- Latency: exactly 1 cycle from request accept to out_valid.
- Extension rules, with p = payload:
  - 00: {24{p[7]}, p[7:0]}
  - 01: {24'b0, p[7:0]}
  - 10: {16{p[15]}, p[15:0]}
  - 11: {16'b0, p[15:0]}
  - For byte kinds, bits p[15:8] are ignored.
- Drain:
  - out_valid=1 and out_ready=1 with no new accept in the same cycle: next out_valid=0, state=EMPTY.
  - Drain and accept in the same cycle: the register reloads and out_valid stays 1.
- Backpressure: while FULL and out_ready=0, all outputs are held stable and the pointer is unchanged.
- Requesters may drop req_valid before they are granted; no grant state is held across cycles.
- The pointer advances only on an accept, never on idle cycles.
- Reset asserted mid-transfer: the held result is discarded and the block returns to the reset values on the next edge, regardless of out_ready.
- out_data, out_kind and out_src are don't-care when out_valid=0, but they hold their last value (no X).

Optional Feature:
- Macro: INT_EXT_ARB_STATS_EN.
- When defined, adds one extra port: neg_count, output, 16 bits.
  - Counts accepted requests whose extended result has bit 31 = 1, i.e. signed kinds with a negative payload.
  - Increments on the accept edge and wraps from 0xFFFF to 0x0000.
  - Reset value is 0.
- When not defined: the port and the counter are absent, and the rest of the behaviour is identical.

Test Plan:
- Extension table: requester 0 sends four transfers:
  - kind 00, data 0x00FF -> out_data 0xFFFFFFFF
  - kind 01, data 0x00FE -> 0x000000FE
  - kind 10, data 0xFFFD -> 0xFFFFFFFD
  - kind 11, data 0xFFFC -> 0x0000FFFC
  - Each result appears 1 cycle after its accept.
- Round-robin: all 4 requesters hold valid; out_ready=1 continuously.
  - Required out_src sequence: 0,1,2,3,0,1.
  - One result per cycle, and req_ready is one-hot each cycle.
- Backpressure: hold out_ready=0 for 5 cycles after the first result.
  - out_data, out_kind and out_src stay stable; req_ready=0 throughout.
  - The next grant occurs in the cycle out_ready returns to 1.
- Sparse requests: only requesters 1 and 3 are valid, with the pointer starting at 2.
  - Grant order: 3, 1, 3.
  - Requester 3 dropping valid before its grant yields grant 1 only.
- Reset mid-operation: with state FULL and out_ready=0, pulse rst for 1 cycle.
  - Next cycle: out_valid=0 and req_ready=0.
  - The pointer restarts at 0, so the first grant goes to the lowest valid requester.
- With INT_EXT_ARB_STATS_EN: accept kinds 00/0x0080, 01/0x0080, 10/0x8000 and 10/0x7FFF.
  - Required: neg_count = 2.
  - Preloading 0xFFFF via 65535 negative accepts, then one more negative accept, gives neg_count = 0x0000.
